known_ch_table: RTL and testbench
=================================

KNOWN_CH_TABLE -- requirements
Module: known_ch_table

Interface
- REQ-001 Parameter WORD_WIDTH, default 16, width of ID, hop count, Q-value and limit fields.
- REQ-002 Parameter DEPTH, default 8, max stored cluster-head (CH) entries; legal range 2..64.
- REQ-003 clk  in  1  single clock; all state updates on rising edge.
- REQ-004 nrst  in  1  reset, synchronous, active-low.
- REQ-005 en_KCH  in  1  one-cycle strobe: fCH_* carry one received CH advertisement.
- REQ-006 HB_reset  in  1  heartbeat level; while high, table cleared and limit latched.
- REQ-007 HB_CHlimit  in  WORD_WIDTH  max CHs to track this round.
- REQ-008 fCH_ID, fCH_Hops, fCH_QValue  in  WORD_WIDTH each  advertised CH ID, hops, Q-value (unsigned Q2.14).
- REQ-009 busy  out  1  update in progress; en_KCH ignored while high.
- REQ-010 kch_drop  out  1  one-cycle pulse when an en_KCH strobe is discarded.
- REQ-011 kch_valid  out  1  chosenCH/hopsfromCH/chosenQValue hold a real selection.
- REQ-012 chosenCH, hopsfromCH, chosenQValue  out  WORD_WIDTH each  best CH, its hops, its Q.
- REQ-013 kch_count  out  $clog2(DEPTH+1)  occupied entries; kch_full  out  1  kch_count == effective limit.

Function
- REQ-014 Effective limit = min(latched HB_CHlimit, DEPTH); limit 0 means every new ID is rejected.
- REQ-015 FSM states IDLE, LOOKUP, UPDATE, SELECT; IDLE->LOOKUP on en_KCH accepted, LOOKUP->UPDATE after exactly DEPTH cycles, UPDATE->SELECT after 1 cycle, SELECT->IDLE after exactly DEPTH cycles.
- REQ-016 en_KCH accepted only in IDLE with HB_reset low and fCH_Hops != all-ones; fields latched on the accepting edge; otherwise kch_drop pulses the following cycle.
- REQ-017 busy is high from the edge after acceptance through the edge returning to IDLE (2*DEPTH+1 cycles); outputs update on that final edge.
- REQ-018 LOOKUP scans one slot per cycle over all DEPTH slots, recording matching-ID index and worst valid entry (lowest Q; tie higher hops; tie higher index).
- REQ-019 UPDATE: ID match -> overwrite hops and Q in place; else count < limit -> write at index count, count+1; else new Q strictly > worst Q -> replace worst slot; else no write and kch_drop pulses.
- REQ-020 SELECT picks max Q among valid slots; tie fewer hops; tie lower index; kch_valid = (count > 0).
- REQ-021 All Q and hop comparisons unsigned, full WORD_WIDTH, no saturation or arithmetic on stored fields.
- REQ-022 HB_reset high (any state) returns FSM to IDLE, clears all slot valids, count 0, outputs to reset values, discards in-progress update, latches HB_CHlimit every such cycle; HB_reset wins over simultaneous en_KCH (kch_drop pulses).
- REQ-023 kch_full recomputed combinationally from count and effective limit.

Reset
- REQ-024 nrst low at an edge: FSM IDLE, all slots invalid, count 0, limit 0, busy 0, kch_drop 0, kch_valid 0, chosenCH 0, hopsfromCH all-ones, chosenQValue 0; applies mid-operation with no partial write.
- REQ-025 First en_KCH is accepted on the first edge after nrst deasserts if other conditions hold.

Verification (DEPTH=8)
- REQ-026 Reset, HB_reset high with limit 3, low; en_KCH ID 23 hops 2 Q 0x3000 -> busy 17 cycles, then chosenCH 23, hopsfromCH 2, chosenQValue 0x3000, count 1, valid 1.
- REQ-027 Add ID 7 hops 1 Q 0x3000 -> chosen 7 (tie, fewer hops); add ID 9 hops 3 Q 0x3800 -> chosen 9, count 3, kch_full 1.
- REQ-028 Full table: ID 40 Q 0x2000 -> kch_drop pulse, count 3, chosen 9; ID 41 hops 4 Q 0x3C00 -> replaces ID 23, chosen 41.
- REQ-029 Update ID 41 to Q 0x1000 -> count unchanged, chosen 9; later limit 0 heartbeat -> valid 0, hopsfromCH 0xFFFF, and any new ID dropped.
- REQ-030 en_KCH while busy -> kch_drop, table unchanged; HB_reset during SELECT -> next cycle busy 0, count 0, valid 0.
- REQ-031 nrst low during LOOKUP -> all outputs at reset values next cycle, no entry written.

Source files
------------

// File: rtl/known_ch_table.sv
// rtl/known_ch_table.sv - known cluster-head table: scans, updates and selects the best advertised CH
module known_ch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en_KCH,
  input  logic                         HB_reset,
  input  logic [WORD_WIDTH-1:0]        HB_CHlimit,
  input  logic [WORD_WIDTH-1:0]        fCH_ID,
  input  logic [WORD_WIDTH-1:0]        fCH_Hops,
  input  logic [WORD_WIDTH-1:0]        fCH_QValue,
  output logic                         busy,
  output logic                         kch_drop,
  output logic                         kch_valid,
  output logic [WORD_WIDTH-1:0]        chosenCH,
  output logic [WORD_WIDTH-1:0]        hopsfromCH,
  output logic [WORD_WIDTH-1:0]        chosenQValue,
  output logic [$clog2(DEPTH+1)-1:0]   kch_count,
  output logic                         kch_full
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, SELECT} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [DEPTH-1:0]      slot_valid;
  logic [WORD_WIDTH-1:0] slot_id   [DEPTH];
  logic [WORD_WIDTH-1:0] slot_hops [DEPTH];
  logic [WORD_WIDTH-1:0] slot_q    [DEPTH];
  logic [CW-1:0]         count;
  logic [WORD_WIDTH-1:0] limit_q;
  logic [CW-1:0]         eff_limit;

  logic [WORD_WIDTH-1:0] new_id, new_hops, new_q;
  logic                  match_found, worst_found, best_found;
  logic [IW-1:0]         match_idx, worst_idx;
  logic [WORD_WIDTH-1:0] worst_q, worst_hops;
  logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;

  logic accept, id_hit, take_worst, take_best;

  assign kch_count = count;

  always_comb begin
    eff_limit  = (limit_q >= WORD_WIDTH'(DEPTH)) ? CW'(DEPTH) : CW'(limit_q);
    kch_full   = (count == eff_limit);
    accept     = (state == IDLE) && en_KCH && !HB_reset && (fCH_Hops != '1);
    id_hit     = slot_valid[idx] && (slot_id[idx] == new_id);
    // Worst: lowest Q, then higher hops, then later index (>= lets later slots win ties)
    take_worst = slot_valid[idx] &&
                 (!worst_found || (slot_q[idx] < worst_q) ||
                  ((slot_q[idx] == worst_q) && (slot_hops[idx] >= worst_hops)));
    // Best: highest Q, then fewer hops, then earlier index (strict compare keeps earlier slot)
    take_best  = slot_valid[idx] &&
                 (!best_found || (slot_q[idx] > best_q) ||
                  ((slot_q[idx] == best_q) && (slot_hops[idx] < best_hops)));
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      idx          <= '0;
      slot_valid   <= '0;
      count        <= '0;
      limit_q      <= '0;
      busy         <= 1'b0;
      kch_drop     <= 1'b0;
      kch_valid    <= 1'b0;
      chosenCH     <= '0;
      hopsfromCH   <= '1;
      chosenQValue <= '0;
      match_found  <= 1'b0;
      worst_found  <= 1'b0;
      best_found   <= 1'b0;
    end else if (HB_reset) begin
      state        <= IDLE;
      idx          <= '0;
      slot_valid   <= '0;
      count        <= '0;
      limit_q      <= HB_CHlimit;
      busy         <= 1'b0;
      kch_drop     <= en_KCH;
      kch_valid    <= 1'b0;
      chosenCH     <= '0;
      hopsfromCH   <= '1;
      chosenQValue <= '0;
      match_found  <= 1'b0;
      worst_found  <= 1'b0;
      best_found   <= 1'b0;
    end else begin
      kch_drop <= en_KCH && !accept;
      case (state)
        IDLE: begin
          if (accept) begin
            new_id      <= fCH_ID;
            new_hops    <= fCH_Hops;
            new_q       <= fCH_QValue;
            match_found <= 1'b0;
            worst_found <= 1'b0;
            idx         <= '0;
            busy        <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (id_hit) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (take_worst) begin
            worst_found <= 1'b1;
            worst_idx   <= idx;
            worst_q     <= slot_q[idx];
            worst_hops  <= slot_hops[idx];
          end
          if (idx == IW'(DEPTH-1)) begin
            idx   <= '0;
            state <= UPDATE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        UPDATE: begin
          if (match_found) begin
            slot_hops[match_idx] <= new_hops;
            slot_q[match_idx]    <= new_q;
          end else if (count < eff_limit) begin
            // Entries are never removed individually, so occupied slots are always 0..count-1
            slot_valid[IW'(count)] <= 1'b1;
            slot_id[IW'(count)]    <= new_id;
            slot_hops[IW'(count)]  <= new_hops;
            slot_q[IW'(count)]     <= new_q;
            count                  <= count + 1'b1;
          end else if (worst_found && (new_q > worst_q)) begin
            slot_id[worst_idx]   <= new_id;
            slot_hops[worst_idx] <= new_hops;
            slot_q[worst_idx]    <= new_q;
          end else begin
            kch_drop <= 1'b1;
          end
          best_found <= 1'b0;
          idx        <= '0;
          state      <= SELECT;
        end
        SELECT: begin
          if (take_best) begin
            best_found <= 1'b1;
            best_id    <= slot_id[idx];
            best_hops  <= slot_hops[idx];
            best_q     <= slot_q[idx];
          end
          if (idx == IW'(DEPTH-1)) begin
            if (take_best) begin
              chosenCH     <= slot_id[idx];
              hopsfromCH   <= slot_hops[idx];
              chosenQValue <= slot_q[idx];
            end else if (best_found) begin
              chosenCH     <= best_id;
              hopsfromCH   <= best_hops;
              chosenQValue <= best_q;
            end else begin
              chosenCH     <= '0;
              hopsfromCH   <= '1;
              chosenQValue <= '0;
            end
            kch_valid <= (count != '0);
            busy      <= 1'b0;
            idx       <= '0;
            state     <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_known_ch_table.sv
// tb/tb_known_ch_table.sv - scoreboard bench for known_ch_table against a list-based table model
module tb_known_ch_table;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_KCH;
  logic        HB_reset;
  logic [15:0] HB_CHlimit;
  logic [15:0] fCH_ID, fCH_Hops, fCH_QValue;
  logic        busy, kch_drop, kch_valid, kch_full;
  logic [15:0] chosenCH, hopsfromCH, chosenQValue;
  logic [3:0]  kch_count;

  known_ch_table #(.WORD_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .nrst(nrst), .en_KCH(en_KCH), .HB_reset(HB_reset), .HB_CHlimit(HB_CHlimit),
    .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue),
    .busy(busy), .kch_drop(kch_drop), .kch_valid(kch_valid),
    .chosenCH(chosenCH), .hopsfromCH(hopsfromCH), .chosenQValue(chosenQValue),
    .kch_count(kch_count), .kch_full(kch_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic [15:0] hops;
    logic [15:0] q;
  } ent_t;

  typedef struct {
    int          kind;   // 0 = drop pulse, 1 = completed update
    logic [15:0] id;
    logic [15:0] hops;
    logic [15:0] q;
    logic        valid;
    int          cnt;
    logic        full;
  } exp_t;

  ent_t tbl[$];
  int   lim;
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int eff_limit();
    return (lim < 8) ? lim : 8;
  endfunction

  function automatic void push_drop();
    exp_t e;
    e = '{default: 0};
    e.kind = 0;
    sbq.push_back(e);
  endfunction

  // Apply one advertisement to the model; returns 1 when the table rejects it
  function automatic bit model_apply(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
    int w;
    foreach (tbl[i]) begin
      if (tbl[i].id == id) begin
        tbl[i].hops = hops;
        tbl[i].q    = q;
        return 0;
      end
    end
    if (tbl.size() < eff_limit()) begin
      tbl.push_back('{id: id, hops: hops, q: q});
      return 0;
    end
    if (tbl.size() == 0) return 1;
    w = 0;
    foreach (tbl[i])
      if (tbl[i].q < tbl[w].q || (tbl[i].q == tbl[w].q && tbl[i].hops >= tbl[w].hops)) w = i;
    if (q > tbl[w].q) begin
      tbl[w] = '{id: id, hops: hops, q: q};
      return 0;
    end
    return 1;
  endfunction

  function automatic exp_t model_result();
    exp_t r;
    int   b;
    r.kind  = 1;
    r.id    = 16'h0;
    r.hops  = 16'hFFFF;
    r.q     = 16'h0;
    r.valid = (tbl.size() > 0);
    r.cnt   = tbl.size();
    r.full  = (tbl.size() == eff_limit());
    b = -1;
    foreach (tbl[i])
      if (b < 0 || tbl[i].q > tbl[b].q || (tbl[i].q == tbl[b].q && tbl[i].hops < tbl[b].hops)) b = i;
    if (b >= 0) begin
      r.id   = tbl[b].id;
      r.hops = tbl[b].hops;
      r.q    = tbl[b].q;
    end
    return r;
  endfunction

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    checks++;
    ok = 0;
    e  = '{default: 0};
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none", kind);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind) begin
        failures++;
        $display("FAIL event_kind actual=%0d expected=%0d", kind, e.kind);
      end else begin
        ok = 1;
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and pops the scoreboard
  int busy_len = 0;
  bit prev_busy = 0;
  always begin
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    if (kch_drop === 1'b1) pop_expect(0, e, ok);
    if (nrst && !HB_reset && prev_busy && !busy) begin
      pop_expect(1, e, ok);
      if (ok) begin
        chk("res_chosenCH", 32'(chosenCH), 32'(e.id));
        chk("res_hops", 32'(hopsfromCH), 32'(e.hops));
        chk("res_q", 32'(chosenQValue), 32'(e.q));
        chk("res_valid", 32'(kch_valid), 32'(e.valid));
        chk("res_count", 32'(kch_count), 32'(e.cnt));
        chk("res_full", 32'(kch_full), 32'(e.full));
      end
      chk("busy_len", 32'(busy_len), 32'd17);
    end
    if (!nrst || HB_reset) begin
      busy_len  = 0;
      prev_busy = 0;
    end else begin
      busy_len  = busy ? busy_len + 1 : 0;
      prev_busy = busy;
    end
  end

  task automatic strobe(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
    @(negedge clk);
    en_KCH = 1'b1; fCH_ID = id; fCH_Hops = hops; fCH_QValue = q;
    @(negedge clk);
    en_KCH = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // inject > 0: strobe a second advertisement that many cycles into the update
  task automatic send(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q, input int inject);
    exp_t r;
    bit   d;
    if (hops == 16'hFFFF) begin
      push_drop();
      strobe(id, hops, q);
      repeat (2) @(negedge clk);
      return;
    end
    d = model_apply(id, hops, q);
    r = model_result();
    if (inject == 0) begin
      if (d) push_drop();
      sbq.push_back(r);
    end
    strobe(id, hops, q);
    if (inject > 0) begin
      repeat (inject) @(negedge clk);
      en_KCH = 1'b1; fCH_ID = 16'($urandom_range(0, 11)); fCH_Hops = 16'($urandom_range(0, 5));
      fCH_QValue = 16'($urandom);
      push_drop();
      @(negedge clk);
      en_KCH = 1'b0;
      if (d) push_drop();
      sbq.push_back(r);
    end
    wait_idle();
  endtask

  task automatic hb(input logic [15:0] limit, input bit with_en);
    @(negedge clk);
    HB_reset = 1'b1; HB_CHlimit = limit;
    if (with_en) begin
      en_KCH = 1'b1; fCH_ID = 16'd3; fCH_Hops = 16'd1; fCH_QValue = 16'h2000;
      push_drop();
    end
    @(negedge clk);
    HB_reset = 1'b0; en_KCH = 1'b0;
    tbl.delete();
    lim = int'(limit);
    chk("hb_count", 32'(kch_count), 32'd0);
    chk("hb_valid", 32'(kch_valid), 32'd0);
    chk("hb_hops", 32'(hopsfromCH), 32'hFFFF);
  endtask

  initial begin
    nrst = 1'b0; en_KCH = 1'b0; HB_reset = 1'b0; HB_CHlimit = '0;
    fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
    lim = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(kch_drop), 32'd0);
    chk("rst_valid", 32'(kch_valid), 32'd0);
    chk("rst_ch", 32'(chosenCH), 32'd0);
    chk("rst_hops", 32'(hopsfromCH), 32'hFFFF);
    chk("rst_q", 32'(chosenQValue), 32'd0);
    chk("rst_count", 32'(kch_count), 32'd0);
    chk("rst_full", 32'(kch_full), 32'd1);
    nrst = 1'b1;

    hb(16'd3, 1'b0);
    send(16'd23, 16'd2, 16'h3000, 0);
    chk("d_first_ch", 32'(chosenCH), 32'd23);
    send(16'd7, 16'd1, 16'h3000, 0);
    chk("d_tie_ch", 32'(chosenCH), 32'd7);
    send(16'd9, 16'd3, 16'h3800, 0);
    chk("d_full", 32'(kch_full), 32'd1);
    send(16'd40, 16'd5, 16'h2000, 0);
    chk("d_drop_ch", 32'(chosenCH), 32'd9);
    send(16'd41, 16'd4, 16'h3C00, 0);
    chk("d_replace_ch", 32'(chosenCH), 32'd41);
    send(16'd41, 16'd4, 16'h1000, 0);
    chk("d_update_ch", 32'(chosenCH), 32'd9);
    chk("d_update_cnt", 32'(kch_count), 32'd3);
    send(16'd7, 16'd2, 16'h3400, 3);
    send(16'd12, 16'hFFFF, 16'h3F00, 0);

    // Heartbeat landing in SELECT aborts the update without writing anything visible
    strobe(16'd55, 16'd1, 16'h3F00);
    repeat (11) @(negedge clk);
    HB_reset = 1'b1; HB_CHlimit = 16'd4;
    @(negedge clk);
    chk("hbsel_busy", 32'(busy), 32'd0);
    chk("hbsel_count", 32'(kch_count), 32'd0);
    chk("hbsel_valid", 32'(kch_valid), 32'd0);
    HB_reset = 1'b0;
    tbl.delete();
    lim = 4;
    send(16'd5, 16'd2, 16'h2800, 0);

    // nrst during LOOKUP
    strobe(16'd60, 16'd1, 16'h3F00);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tbl.delete();
    lim = 0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_count", 32'(kch_count), 32'd0);
    chk("rstmid_ch", 32'(chosenCH), 32'd0);
    chk("rstmid_hops", 32'(hopsfromCH), 32'hFFFF);
    send(16'd61, 16'd1, 16'h3000, 0);
    chk("lim0_valid", 32'(kch_valid), 32'd0);

    hb(16'd0, 1'b1);
    send(16'd62, 16'd2, 16'h3000, 0);
    chk("lim0b_hops", 32'(hopsfromCH), 32'hFFFF);

    for (int r = 0; r < 4; r++) begin
      hb(16'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 12; k++) begin
        logic [15:0] id, hops, q;
        int inj;
        id   = 16'($urandom_range(0, 11));
        hops = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 5));
        q    = 16'($urandom_range(0, 7) << 11);
        inj  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 5)) : 0;
        send(id, hops, q, inj);
      end
    end

    begin
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
